// File: rtl/mem_arbiter_if.sv
// Signal bundle linking mem_arbiter to the CPU requester, vga_ctrl and the shared memory port.
// master = arbiter side, slave = everything the arbiter talks to.
interface mem_arbiter_if #(
  parameter int DATAWIDTH = 16,
  parameter int ADDRWIDTH = 16
);
  logic [2:0]           acnt;
  logic [ADDRWIDTH-1:0] vga_addr;
  logic [DATAWIDTH-1:0] glyph_num;
  logic [DATAWIDTH-1:0] glyph_pixels;
  logic                 cpu_req;
  logic                 cpu_we;
  logic [ADDRWIDTH-1:0] cpu_addr;
  logic [DATAWIDTH-1:0] cpu_wdata;
  logic [DATAWIDTH-1:0] cpu_rdata;
  logic                 cpu_ack;
  logic                 mem_en;
  logic                 mem_we;
  logic [ADDRWIDTH-1:0] mem_addr;
  logic [DATAWIDTH-1:0] mem_wdata;
  logic [DATAWIDTH-1:0] mem_rdata;

  modport master (
    output acnt, glyph_num, glyph_pixels, cpu_rdata, cpu_ack,
           mem_en, mem_we, mem_addr, mem_wdata,
    input  vga_addr, cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_rdata
  );

  modport slave (
    input  acnt, glyph_num, glyph_pixels, cpu_rdata, cpu_ack,
           mem_en, mem_we, mem_addr, mem_wdata,
    output vga_addr, cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_rdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// Time-division arbiter for the shared frame-buffer/glyph-ROM port: two fixed VGA read slots
// per 8-clock frame, remaining slots granted to a single req/ack CPU port.
module mem_arbiter #(
  parameter int DATAWIDTH = 16,
  parameter int ADDRWIDTH = 16,
  parameter int FB_SLOT   = 1,
  parameter int ROM_SLOT  = 3
) (
  input  logic          clk,
  input  logic          rst,
  mem_arbiter_if.master bus
);
  localparam logic [2:0] FbSlot  = 3'(FB_SLOT);
  localparam logic [2:0] RomSlot = 3'(ROM_SLOT);
  localparam logic [2:0] FbLoad  = 3'(FB_SLOT + 1);
  localparam logic [2:0] RomLoad = 3'(ROM_SLOT + 1);

  typedef enum logic {
    IDLE,
    ACK
  } state_e;

  state_e               state_q, state_d;
  logic [2:0]           acnt_q, acnt_d;
  logic [DATAWIDTH-1:0] glyph_num_q, glyph_num_d;
  logic [DATAWIDTH-1:0] glyph_pixels_q, glyph_pixels_d;
  logic [DATAWIDTH-1:0] cpu_rdata_q, cpu_rdata_d;
  logic                 rd_q, rd_d;

  logic                 vga_slot;
  logic                 mem_en;
  logic                 mem_we;
  logic [ADDRWIDTH-1:0] mem_addr;
  logic [DATAWIDTH-1:0] mem_wdata;
  logic                 cpu_ack;
  logic [DATAWIDTH-1:0] cpu_rdata;

  // NOTE: sequential state uses non-blocking assignments only, so every register samples
  // the values from before the edge regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q        <= IDLE;
      acnt_q         <= '0;
      glyph_num_q    <= '0;
      glyph_pixels_q <= '0;
      cpu_rdata_q    <= '0;
      rd_q           <= 1'b0;
    end else begin
      state_q        <= state_d;
      acnt_q         <= acnt_d;
      glyph_num_q    <= glyph_num_d;
      glyph_pixels_q <= glyph_pixels_d;
      cpu_rdata_q    <= cpu_rdata_d;
      rd_q           <= rd_d;
    end
  end

  // NOTE: every variable gets a default at the top of the block so no path leaves one
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d        = state_q;
    acnt_d         = acnt_q + 3'd1;
    glyph_num_d    = glyph_num_q;
    glyph_pixels_d = glyph_pixels_q;
    cpu_rdata_d    = cpu_rdata_q;
    rd_d           = rd_q;
    mem_en         = 1'b0;
    mem_we         = 1'b0;
    mem_addr       = '0;
    mem_wdata      = '0;
    cpu_ack        = 1'b0;
    cpu_rdata      = cpu_rdata_q;

    vga_slot = (acnt_q == FbSlot) || (acnt_q == RomSlot);

    // VGA read data arrives one slot after each fetch is issued.
    if (acnt_q == FbLoad)  glyph_num_d    = bus.mem_rdata;
    if (acnt_q == RomLoad) glyph_pixels_d = bus.mem_rdata;

    if (vga_slot) begin
      mem_en   = rst;
      mem_addr = bus.vga_addr;
    end

    case (state_q)
      IDLE: begin
        if (rst && bus.cpu_req && !vga_slot) begin
          mem_en    = 1'b1;
          mem_we    = bus.cpu_we;
          mem_addr  = bus.cpu_addr;
          mem_wdata = bus.cpu_we ? bus.cpu_wdata : '0;
          rd_d      = !bus.cpu_we;
          state_d   = ACK;
        end
      end
      ACK: begin
        // A reset landing in the ack cycle abandons the access without acknowledging it.
        cpu_ack = rst;
        state_d = IDLE;
        if (rd_q && rst) begin
          cpu_rdata   = bus.mem_rdata;
          cpu_rdata_d = bus.mem_rdata;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.acnt         = acnt_q;
  assign bus.glyph_num    = glyph_num_q;
  assign bus.glyph_pixels = glyph_pixels_q;
  assign bus.cpu_rdata    = cpu_rdata;
  assign bus.cpu_ack      = cpu_ack;
  assign bus.mem_en       = mem_en;
  assign bus.mem_we       = mem_we;
  assign bus.mem_addr     = mem_addr;
  assign bus.mem_wdata    = mem_wdata;
endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios with literal expectations, then randomized traffic
// checked every cycle against a slot/pending-access reference model.
module tb_mem_arbiter;
  localparam int DW = 16;
  localparam int AW = 16;

  logic clk = 1'b0;
  logic rst;

  mem_arbiter_if #(.DATAWIDTH(DW), .ADDRWIDTH(AW)) bus ();

  mem_arbiter #(
    .DATAWIDTH(DW),
    .ADDRWIDTH(AW),
    .FB_SLOT  (1),
    .ROM_SLOT (3)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: slot number of the current cycle, whether a CPU access was issued last
  // cycle (and whether it was a read), and the values the latched outputs must hold.
  int          m_slot     = 0;
  bit          m_pend     = 1'b0;
  bit          m_pend_rd  = 1'b0;
  logic [15:0] m_rdata    = '0;
  logic [15:0] m_gnum     = '0;
  logic [15:0] m_gpix     = '0;
  bit          model_live = 1'b0;
  bit          e_ack      = 1'b0;

  bit md_vga, md_issue;
  always @(posedge clk) begin
    if (!rst) begin
      m_slot    = 0;
      m_pend    = 1'b0;
      m_pend_rd = 1'b0;
      m_rdata   = '0;
      m_gnum    = '0;
      m_gpix    = '0;
    end else begin
      md_vga   = (m_slot == 1) || (m_slot == 3);
      md_issue = bus.cpu_req && !m_pend && !md_vga;
      if (m_slot == 2) m_gnum = bus.mem_rdata;
      if (m_slot == 4) m_gpix = bus.mem_rdata;
      if (m_pend && m_pend_rd) m_rdata = bus.mem_rdata;
      m_pend    = md_issue;
      m_pend_rd = md_issue && !bus.cpu_we;
      m_slot    = (m_slot + 1) % 8;
    end
    model_live = 1'b1;
  end

  bit c_vga, c_issue;
  always @(negedge clk) begin
    if (model_live) begin
      c_vga   = (m_slot == 1) || (m_slot == 3);
      c_issue = rst && bus.cpu_req && !m_pend && !c_vga;
      e_ack   = rst && m_pend;
      check("acnt", 32'(bus.acnt), 32'(m_slot));
      check("mem_en", 32'(bus.mem_en), 32'(rst && (c_vga || c_issue)));
      check("mem_we", 32'(bus.mem_we), 32'(c_issue && bus.cpu_we));
      if (rst && c_vga) check("mem_addr_vga", 32'(bus.mem_addr), 32'(bus.vga_addr));
      else if (c_issue) check("mem_addr_cpu", 32'(bus.mem_addr), 32'(bus.cpu_addr));
      check("mem_wdata", 32'(bus.mem_wdata),
            32'((c_issue && bus.cpu_we) ? bus.cpu_wdata : 16'h0000));
      check("cpu_ack", 32'(bus.cpu_ack), 32'(e_ack));
      check("cpu_rdata", 32'(bus.cpu_rdata),
            32'((e_ack && m_pend_rd) ? bus.mem_rdata : m_rdata));
      check("glyph_num", 32'(bus.glyph_num), 32'(m_gnum));
      check("glyph_pixels", 32'(bus.glyph_pixels), 32'(m_gpix));
    end
  end

  task automatic goto_slot(input int s);
    for (int k = 0; k < 8 && m_slot != s; k++) tick();
  endtask

  initial begin
    int  acks;
    int  ens;
    bit  rst_prev;

    rst           = 1'b0;
    bus.cpu_req   = 1'b1;
    bus.cpu_we    = 1'b0;
    bus.cpu_addr  = '0;
    bus.cpu_wdata = '0;
    bus.vga_addr  = '0;
    bus.mem_rdata = '0;

    // Reset held with a pending request, then free-running count after release.
    repeat (3) tick();
    @(negedge clk);
    check("rst_acnt", 32'(bus.acnt), 32'd0);
    check("rst_mem_en", 32'(bus.mem_en), 32'd0);
    check("rst_mem_we", 32'(bus.mem_we), 32'd0);
    check("rst_ack", 32'(bus.cpu_ack), 32'd0);
    check("rst_glyph_num", 32'(bus.glyph_num), 32'd0);
    check("rst_glyph_pixels", 32'(bus.glyph_pixels), 32'd0);
    check("rst_rdata", 32'(bus.cpu_rdata), 32'd0);
    tick();
    rst         = 1'b1;
    bus.cpu_req = 1'b0;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      check("seq_acnt", 32'(bus.acnt), 32'(i % 8));
      tick();
    end

    // VGA fetches in slots 1 and 3, data latched one slot later.
    goto_slot(1);
    bus.vga_addr = 16'h0F00;
    @(negedge clk);
    check("fb_en", 32'(bus.mem_en), 32'd1);
    check("fb_addr", 32'(bus.mem_addr), 32'h0F00);
    tick();
    bus.vga_addr  = 16'h0000;
    bus.mem_rdata = 16'h4142;
    tick();
    bus.vga_addr  = 16'h0123;
    bus.mem_rdata = 16'h0000;
    @(negedge clk);
    check("glyph_num_val", 32'(bus.glyph_num), 32'h4142);
    check("rom_addr", 32'(bus.mem_addr), 32'h0123);
    tick();
    bus.vga_addr  = 16'h0000;
    bus.mem_rdata = 16'hAA55;
    tick();
    bus.mem_rdata = 16'h0000;
    @(negedge clk);
    check("glyph_pixels_val", 32'(bus.glyph_pixels), 32'hAA55);

    // CPU read issued in slot 4, acknowledged in slot 5.
    goto_slot(4);
    bus.cpu_req  = 1'b1;
    bus.cpu_we   = 1'b0;
    bus.cpu_addr = 16'h0200;
    @(negedge clk);
    check("rd_en", 32'(bus.mem_en), 32'd1);
    check("rd_we", 32'(bus.mem_we), 32'd0);
    check("rd_addr", 32'(bus.mem_addr), 32'h0200);
    tick();
    bus.mem_rdata = 16'hBEEF;
    @(negedge clk);
    check("rd_ack", 32'(bus.cpu_ack), 32'd1);
    check("rd_data", 32'(bus.cpu_rdata), 32'hBEEF);
    tick();
    bus.cpu_req   = 1'b0;
    bus.mem_rdata = 16'h0000;
    @(negedge clk);
    check("rd_hold", 32'(bus.cpu_rdata), 32'hBEEF);
    check("ack_pulse", 32'(bus.cpu_ack), 32'd0);

    // Write requested in the FB slot waits one cycle; its ack overlaps the ROM fetch.
    goto_slot(1);
    bus.vga_addr  = 16'h0F00;
    bus.cpu_req   = 1'b1;
    bus.cpu_we    = 1'b1;
    bus.cpu_addr  = 16'h0300;
    bus.cpu_wdata = 16'h1234;
    @(negedge clk);
    check("cf_vga_addr", 32'(bus.mem_addr), 32'h0F00);
    check("cf_vga_we", 32'(bus.mem_we), 32'd0);
    check("cf_wdata_idle", 32'(bus.mem_wdata), 32'd0);
    tick();
    bus.vga_addr = 16'h0000;
    @(negedge clk);
    check("cf_wr_en", 32'(bus.mem_en), 32'd1);
    check("cf_wr_we", 32'(bus.mem_we), 32'd1);
    check("cf_wr_addr", 32'(bus.mem_addr), 32'h0300);
    check("cf_wr_data", 32'(bus.mem_wdata), 32'h1234);
    tick();
    bus.vga_addr = 16'h0123;
    @(negedge clk);
    check("cf_ack", 32'(bus.cpu_ack), 32'd1);
    check("cf_rom_addr", 32'(bus.mem_addr), 32'h0123);
    check("cf_rom_we", 32'(bus.mem_we), 32'd0);
    check("cf_rdata_keep", 32'(bus.cpu_rdata), 32'hBEEF);
    tick();
    bus.cpu_req  = 1'b0;
    bus.cpu_we   = 1'b0;
    bus.vga_addr = 16'h0000;

    // Continuous request over one 8-slot frame: issues in 0,2,4,6, acks in 1,3,5,7.
    goto_slot(0);
    acks          = 0;
    ens           = 0;
    bus.cpu_req   = 1'b1;
    bus.cpu_we    = 1'($urandom);
    bus.cpu_addr  = 16'($urandom);
    bus.cpu_wdata = 16'($urandom);
    for (int i = 0; i < 8; i++) begin
      bus.mem_rdata = 16'($urandom);
      @(negedge clk);
      if (bus.cpu_ack) acks++;
      if (bus.mem_en) ens++;
      tick();
      if (e_ack) begin
        bus.cpu_we    = 1'($urandom);
        bus.cpu_addr  = 16'($urandom);
        bus.cpu_wdata = 16'($urandom);
      end
    end
    check("b2b_acks", 32'(acks), 32'd4);
    check("b2b_mem_en", 32'(ens), 32'd6);
    bus.cpu_req = 1'b0;

    // Reset during the would-be issue cycle, then reset during an ack cycle.
    goto_slot(4);
    bus.cpu_req  = 1'b1;
    bus.cpu_we   = 1'b0;
    bus.cpu_addr = 16'h0444;
    rst          = 1'b0;
    @(negedge clk);
    check("rst_mid_en", 32'(bus.mem_en), 32'd0);
    tick();
    rst         = 1'b1;
    bus.cpu_req = 1'b0;
    @(negedge clk);
    check("rst_mid_ack", 32'(bus.cpu_ack), 32'd0);
    check("rst_mid_acnt", 32'(bus.acnt), 32'd0);
    goto_slot(4);
    bus.cpu_req = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("rst_ack_gated", 32'(bus.cpu_ack), 32'd0);
    tick();
    rst         = 1'b1;
    bus.cpu_req = 1'b0;
    @(negedge clk);
    check("rst_ack_acnt", 32'(bus.acnt), 32'd0);
    check("rst_ack_none", 32'(bus.cpu_ack), 32'd0);

    // Randomized traffic; the requester holds each request until acked or reset.
    for (int c = 0; c < 3000; c++) begin
      bus.vga_addr  = 16'($urandom);
      bus.mem_rdata = 16'($urandom);
      tick();
      rst_prev = rst;
      if (!bus.cpu_req || e_ack || !rst_prev) begin
        bus.cpu_req   = ($urandom_range(0, 2) != 0);
        bus.cpu_we    = 1'($urandom);
        bus.cpu_addr  = 16'($urandom);
        bus.cpu_wdata = 16'($urandom);
      end
      rst = ($urandom_range(0, 149) != 0);
    end
    rst         = 1'b1;
    bus.cpu_req = 1'b0;
    repeat (2) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
